// File: rtl/physical_regfile_scoreboard.sv
// Physical register file with per-register busy scoreboard.
// Two writeback ports, two rename allocation ports, flush, and four
// combinational read ports with same-cycle write bypass. Register 0 is
// hardwired to zero and never busy.
module physical_regfile_scoreboard #(
    parameter int REG_ADDR_WIDTH = 6,
    parameter int REG_DATA_WIDTH = 64
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      wr_first_valid,
    input  logic [REG_ADDR_WIDTH-1:0] wr_first_address,
    input  logic [REG_DATA_WIDTH-1:0] wr_first_data,
    input  logic                      wr_second_valid,
    input  logic [REG_ADDR_WIDTH-1:0] wr_second_address,
    input  logic [REG_DATA_WIDTH-1:0] wr_second_data,
    input  logic                      alloc0_valid,
    input  logic [REG_ADDR_WIDTH-1:0] alloc0_address,
    input  logic                      alloc1_valid,
    input  logic [REG_ADDR_WIDTH-1:0] alloc1_address,
    input  logic                      flush,
    input  logic [REG_ADDR_WIDTH-1:0] rd0_address,
    input  logic [REG_ADDR_WIDTH-1:0] rd1_address,
    input  logic [REG_ADDR_WIDTH-1:0] rd2_address,
    input  logic [REG_ADDR_WIDTH-1:0] rd3_address,
    output logic [REG_DATA_WIDTH-1:0] rd0_data,
    output logic [REG_DATA_WIDTH-1:0] rd1_data,
    output logic [REG_DATA_WIDTH-1:0] rd2_data,
    output logic [REG_DATA_WIDTH-1:0] rd3_data,
    output logic                      rd0_ready,
    output logic                      rd1_ready,
    output logic                      rd2_ready,
    output logic                      rd3_ready
);

    localparam int DEPTH = 1 << REG_ADDR_WIDTH;
    localparam logic [REG_ADDR_WIDTH-1:0] ZERO_ADDR = '0;

    logic [DEPTH-1:0][REG_DATA_WIDTH-1:0] mem_q;
    logic [DEPTH-1:0]                     busy_q, busy_d;

    // Port qualifiers: writes/allocs to register 0 are dropped here once.
    logic wf_en, ws_en, a0_en, a1_en;
    assign wf_en = wr_first_valid  && (wr_first_address  != ZERO_ADDR);
    assign ws_en = wr_second_valid && (wr_second_address != ZERO_ADDR);
    assign a0_en = alloc0_valid    && (alloc0_address    != ZERO_ADDR);
    assign a1_en = alloc1_valid    && (alloc1_address    != ZERO_ADDR);

    // Data array: wr_first takes precedence when both ports hit one entry.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mem_q <= '0;
        end else begin
            for (int i = 1; i < DEPTH; i++) begin
                if (wf_en && (wr_first_address == REG_ADDR_WIDTH'(i)))
                    mem_q[i] <= wr_first_data;
                else if (ws_en && (wr_second_address == REG_ADDR_WIDTH'(i)))
                    mem_q[i] <= wr_second_data;
            end
        end
    end

    // Scoreboard next state: writeback clears, alloc (new producer) sets
    // over a same-cycle clear, flush wipes everything including allocs.
    always_comb begin
        busy_d = busy_q;
        if (wf_en) busy_d[wr_first_address]  = 1'b0;
        if (ws_en) busy_d[wr_second_address] = 1'b0;
        if (a0_en) busy_d[alloc0_address]    = 1'b1;
        if (a1_en) busy_d[alloc1_address]    = 1'b1;
        if (flush) busy_d = '0;
        busy_d[0] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) busy_q <= '0;
        else       busy_q <= busy_d;
    end

    logic [3:0][REG_ADDR_WIDTH-1:0] rd_addr;
    logic [3:0][REG_DATA_WIDTH-1:0] rd_data;
    logic [3:0]                     rd_rdy;

    assign rd_addr = {rd3_address, rd2_address, rd1_address, rd0_address};

    // Read ports: reset and reg 0 force zero/ready, then bypass, then array.
    // Same-cycle allocs are deliberately not visible here.
    always_comb begin
        for (int p = 0; p < 4; p++) begin
            rd_data[p] = mem_q[rd_addr[p]];
            rd_rdy[p]  = ~busy_q[rd_addr[p]];
            if (!rstn || (rd_addr[p] == ZERO_ADDR)) begin
                rd_data[p] = '0;
                rd_rdy[p]  = 1'b1;
            end else if (wf_en && (wr_first_address == rd_addr[p])) begin
                rd_data[p] = wr_first_data;
                rd_rdy[p]  = 1'b1;
            end else if (ws_en && (wr_second_address == rd_addr[p])) begin
                rd_data[p] = wr_second_data;
                rd_rdy[p]  = 1'b1;
            end
        end
    end

    assign rd0_data  = rd_data[0];
    assign rd1_data  = rd_data[1];
    assign rd2_data  = rd_data[2];
    assign rd3_data  = rd_data[3];
    assign rd0_ready = rd_rdy[0];
    assign rd1_ready = rd_rdy[1];
    assign rd2_ready = rd_rdy[2];
    assign rd3_ready = rd_rdy[3];

endmodule

// File: tb/tb_physical_regfile_scoreboard.sv
// Directed bench for physical_regfile_scoreboard: a table of per-cycle
// vectors plus a hand-written asynchronous-reset sequence.
module tb_physical_regfile_scoreboard;

    logic        clk, rstn;
    logic        wf_v, ws_v, a0_v, a1_v, fl;
    logic [5:0]  wf_a, ws_a, a0_a, a1_a;
    logic [63:0] wf_d, ws_d;
    logic [5:0]  r0_a, r1_a, r2_a, r3_a;
    logic [63:0] r0_d, r1_d, r2_d, r3_d;
    logic        r0_r, r1_r, r2_r, r3_r;

    int checks = 0;
    int errors = 0;

    physical_regfile_scoreboard #(.REG_ADDR_WIDTH(6), .REG_DATA_WIDTH(64)) dut (
        .clk(clk), .rstn(rstn),
        .wr_first_valid(wf_v), .wr_first_address(wf_a), .wr_first_data(wf_d),
        .wr_second_valid(ws_v), .wr_second_address(ws_a), .wr_second_data(ws_d),
        .alloc0_valid(a0_v), .alloc0_address(a0_a),
        .alloc1_valid(a1_v), .alloc1_address(a1_a),
        .flush(fl),
        .rd0_address(r0_a), .rd1_address(r1_a), .rd2_address(r2_a), .rd3_address(r3_a),
        .rd0_data(r0_d), .rd1_data(r1_d), .rd2_data(r2_d), .rd3_data(r3_d),
        .rd0_ready(r0_r), .rd1_ready(r1_r), .rd2_ready(r2_r), .rd3_ready(r3_r)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        wf_v; logic [5:0] wf_a; logic [63:0] wf_d;
        logic        ws_v; logic [5:0] ws_a; logic [63:0] ws_d;
        logic        a0_v; logic [5:0] a0_a;
        logic        a1_v; logic [5:0] a1_a;
        logic        fl;
        logic [5:0]  r0_a; logic [5:0] r1_a;
        logic [63:0] e0_d; logic e0_r;
        logic [63:0] e1_d; logic e1_r;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs[NV];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle();
        wf_v = 0; wf_a = 0; wf_d = 0;
        ws_v = 0; ws_a = 0; ws_d = 0;
        a0_v = 0; a0_a = 0; a1_v = 0; a1_a = 0; fl = 0;
    endtask

    // Checks rd0/rd2 against one expectation and rd1/rd3 against another.
    task automatic chk_ports(input string tag, input logic [63:0] e0d, input logic e0r,
                             input logic [63:0] e1d, input logic e1r);
        chk({tag, " rd0_data"},  r0_d, e0d);
        chk({tag, " rd0_ready"}, 64'(r0_r), 64'(e0r));
        chk({tag, " rd2_data"},  r2_d, e0d);
        chk({tag, " rd2_ready"}, 64'(r2_r), 64'(e0r));
        chk({tag, " rd1_data"},  r1_d, e1d);
        chk({tag, " rd1_ready"}, 64'(r1_r), 64'(e1r));
        chk({tag, " rd3_data"},  r3_d, e1d);
        chk({tag, " rd3_ready"}, 64'(r3_r), 64'(e1r));
    endtask

    task automatic set_rd(input logic [5:0] a0, input logic [5:0] a1);
        r0_a = a0; r2_a = a0; r1_a = a1; r3_a = a1;
    endtask

    initial begin
        //          wf_v wf_a wf_d      ws_v ws_a ws_d       a0  a0a  a1  a1a  fl  r0  r1   e0_d      e0r  e1_d       e1r
        vecs[0]  = '{0, 0,  64'h0,    0, 0,  64'h0,      0, 0,   0, 0,   0,  5,  7,  64'h0,    1,  64'h0,     1};
        vecs[1]  = '{0, 0,  64'h0,    0, 0,  64'h0,      1, 7,   0, 0,   0,  0,  7,  64'h0,    1,  64'h0,     1};
        vecs[2]  = '{0, 0,  64'h0,    0, 0,  64'h0,      0, 0,   0, 0,   0,  5,  7,  64'h0,    1,  64'h0,     0};
        vecs[3]  = '{0, 0,  64'h0,    1, 7,  64'h1234,   0, 0,   0, 0,   0,  7,  7,  64'h1234, 1,  64'h1234,  1};
        vecs[4]  = '{0, 0,  64'h0,    0, 0,  64'h0,      0, 0,   0, 0,   0,  9,  7,  64'h0,    1,  64'h1234,  1};
        vecs[5]  = '{1, 9,  64'h11,   1, 9,  64'h22,     0, 0,   0, 0,   0,  9,  9,  64'h11,   1,  64'h11,    1};
        vecs[6]  = '{0, 0,  64'h0,    0, 0,  64'h0,      1, 12,  0, 0,   0,  9,  12, 64'h11,   1,  64'h0,     1};
        vecs[7]  = '{1, 12, 64'h55,   0, 0,  64'h0,      0, 0,   1, 12,  0,  12, 9,  64'h55,   1,  64'h11,    1};
        vecs[8]  = '{0, 0,  64'h0,    0, 0,  64'h0,      0, 0,   0, 0,   0,  12, 0,  64'h55,   0,  64'h0,     1};
        vecs[9]  = '{1, 0,  64'hFF,   0, 0,  64'h0,      1, 0,   0, 0,   0,  0,  12, 64'h0,    1,  64'h55,    0};
        vecs[10] = '{0, 0,  64'h0,    0, 0,  64'h0,      1, 3,   1, 4,   0,  0,  3,  64'h0,    1,  64'h0,     1};
        vecs[11] = '{0, 0,  64'h0,    0, 0,  64'h0,      1, 63,  0, 0,   0,  3,  4,  64'h0,    0,  64'h0,     0};
        vecs[12] = '{0, 0,  64'h0,    1, 3,  64'h33,     1, 20,  0, 0,   1,  63, 20, 64'h0,    0,  64'h0,     1};
        vecs[13] = '{0, 0,  64'h0,    0, 0,  64'h0,      0, 0,   0, 0,   0,  3,  63, 64'h33,   1,  64'h0,     1};
        vecs[14] = '{0, 0,  64'h0,    0, 0,  64'h0,      0, 0,   0, 0,   0,  4,  20, 64'h0,    1,  64'h0,     1};
        vecs[15] = '{1, 10, 64'hA,    1, 11, 64'hB,      0, 0,   0, 0,   0,  11, 10, 64'hB,    1,  64'hA,     1};
        vecs[16] = '{0, 0,  64'h0,    0, 0,  64'h0,      0, 0,   0, 0,   0,  10, 11, 64'hA,    1,  64'hB,     1};

        // Reset state
        rstn = 1'b0;
        idle();
        set_rd(6'd5, 6'd63);
        #2;
        chk_ports("reset", 64'h0, 1'b1, 64'h0, 1'b1);
        @(negedge clk);
        rstn = 1'b1;

        // Table-driven cycles: drive at negedge, check before the next posedge
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            wf_v = vecs[i].wf_v; wf_a = vecs[i].wf_a; wf_d = vecs[i].wf_d;
            ws_v = vecs[i].ws_v; ws_a = vecs[i].ws_a; ws_d = vecs[i].ws_d;
            a0_v = vecs[i].a0_v; a0_a = vecs[i].a0_a;
            a1_v = vecs[i].a1_v; a1_a = vecs[i].a1_a;
            fl   = vecs[i].fl;
            set_rd(vecs[i].r0_a, vecs[i].r1_a);
            #2;
            chk_ports($sformatf("vec%0d", i), vecs[i].e0_d, vecs[i].e0_r,
                      vecs[i].e1_d, vecs[i].e1_r);
        end

        // Mid-run asynchronous reset: reg 5 written, reg 40 busy beforehand
        @(negedge clk);
        idle();
        wf_v = 1; wf_a = 6'd5; wf_d = 64'hAB;
        set_rd(6'd5, 6'd5);
        @(negedge clk);
        idle();
        a0_v = 1; a0_a = 6'd40;
        set_rd(6'd5, 6'd5);
        #2;
        chk_ports("pre_rst reg5", 64'hAB, 1'b1, 64'hAB, 1'b1);
        @(negedge clk);
        idle();
        set_rd(6'd40, 6'd5);
        #2;
        chk_ports("pre_rst busy40", 64'h0, 1'b0, 64'hAB, 1'b1);
        #1;
        rstn = 1'b0;
        wf_v = 1; wf_a = 6'd5; wf_d = 64'hCD;
        #1;
        chk_ports("in_rst async", 64'h0, 1'b1, 64'h0, 1'b1);
        @(negedge clk);
        chk_ports("in_rst held", 64'h0, 1'b1, 64'h0, 1'b1);
        idle();
        rstn = 1'b1;
        #2;
        chk_ports("post_rst", 64'h0, 1'b1, 64'h0, 1'b1);
        @(negedge clk);
        chk_ports("post_rst edge", 64'h0, 1'b1, 64'h0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/physical_regfile_scoreboard.md
Name: physical_regfile_scoreboard

Overview:
Physical register file that consumes the two arbitrated writeback ports produced by the six-to-two writeback arbiter in the RCU. It holds 2^REG_ADDR_WIDTH physical registers and a per-register busy scoreboard, which rename sets at allocation and writeback clears. It provides four read ports (rs1/rs2 for two dispatching instructions), each returning data plus a ready bit, with same-cycle write bypass.

Parameters:
REG_ADDR_WIDTH, 6, physical register index width; depth is 2^REG_ADDR_WIDTH.
REG_DATA_WIDTH, 64, register data width.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rstn  input  1  asynchronous active-low reset.
wr_first_valid  input  1  write port 0 valid (highest-priority arbitrated writeback).
wr_first_address  input  REG_ADDR_WIDTH  write port 0 physical index.
wr_first_data  input  REG_DATA_WIDTH  write port 0 data.
wr_second_valid  input  1  write port 1 valid.
wr_second_address  input  REG_ADDR_WIDTH  write port 1 physical index.
wr_second_data  input  REG_DATA_WIDTH  write port 1 data.
alloc0_valid  input  1  rename allocates a destination; set busy.
alloc0_address  input  REG_ADDR_WIDTH  allocated index 0.
alloc1_valid  input  1  second rename allocation.
alloc1_address  input  REG_ADDR_WIDTH  allocated index 1.
flush  input  1  pipeline recovery; clear all busy bits.
rd0_address..rd3_address  input  REG_ADDR_WIDTH each  four read indices.
rd0_data..rd3_data  output  REG_DATA_WIDTH each  read data, combinational.
rd0_ready..rd3_ready  output  1 each  operand available (not busy, or bypassed this cycle).

Behaviour:
- Reset (rstn low, asynchronous): every data entry = 0, every busy bit = 0. The reset is applied immediately regardless of clk. While in reset, rdN_data = 0 and rdN_ready = 1. Reset overrides every other input.
- Register 0 is hardwired. Writes to it are ignored and allocations to it are ignored. Reads of it return 0 with ready = 1.
- Write: on the rising edge, for each valid write port with a nonzero address, mem[address] <= data and busy[address] <= 0.
- Both write ports target the same address in one cycle: wr_first wins for data; busy is cleared.
- Allocate: on the rising edge, for each valid alloc port with a nonzero address, busy[address] <= 1.
- Alloc and write to the same address in one cycle: the data is written, and busy is set (alloc wins, because it belongs to the new producer).
- alloc0 and alloc1 with the same address: busy is set once; this is legal but not expected.
- flush: on the rising edge, all busy bits <= 0. This takes priority over same-cycle alloc. Same-cycle writes still update data.
- Read: purely combinational, zero latency.
  - Bypass: if wr_first is valid and its address matches rdN_address (nonzero), return wr_first_data with ready = 1.
  - Else, if wr_second matches, return wr_second_data with ready = 1.
  - Otherwise return mem[rdN_address] with ready = !busy[rdN_address].
  - Bypass ignores same-cycle allocs, because the allocation is visible from the next cycle.
- Multiple read ports may read the same address; each port is independent.
- No handshake back-pressure: every valid write and alloc is accepted every cycle.
- Widths: addresses are used unsigned. No arithmetic.

Test Plan:
- Reset: assert rstn=0 mid-run after writing reg 5 = 0xAB → rd0_address=5 gives data 0, ready 1. Deassert, then reg 5 still reads 0.
- Alloc, then write: alloc0 reg 7 in cycle 0 → cycle 1 rd1 reads reg 7 with ready 0. In cycle 2, wr_second reg 7 = 0x1234 → same cycle rd1 data 0x1234, ready 1 (bypass). Cycle 3: data 0x1234 from array, ready 1.
- Dual write same address: wr_first reg 9 = 0x11 and wr_second reg 9 = 0x22 in the same cycle → bypass returns 0x11, and the next cycle reads 0x11.
- Alloc+write collision: reg 12 busy; in one cycle wr_first reg 12 = 0x55 and alloc1 reg 12 → next cycle data 0x55, ready 0.
- Register 0: wr_first reg 0 = 0xFF plus alloc0 reg 0 → rd2 reads reg 0 with data 0, ready 1, both in that cycle and after.
- Flush: allocate regs 3, 4, 63, then flush with alloc0 reg 20 in the same cycle → next cycle all four read ready 1.
